// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory handshake, redirect/stall controls and decode-side outputs of the fetch stage.
interface fetch_unit_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        stall;
  logic [31:0] pc_out;
  logic [31:0] next_pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;
  modport master (
    output fetch_req, fetch_addr, pc_out, next_pc_out, instruction_out, valid_out,
    input  fetch_ready, fetch_rvalid, fetch_rdata, redirect, redirect_target, stall
  );
  modport slave (
    input  fetch_req, fetch_addr, pc_out, next_pc_out, instruction_out, valid_out,
    output fetch_ready, fetch_rvalid, fetch_rdata, redirect, redirect_target, stall
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and single-outstanding instruction fetch with stall skid buffer and redirect discard.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  fetch_unit_if.master    bus
);
  localparam logic [1:0] REQ = 2'd0, WAIT = 2'd1, HOLD = 2'd2, DISCARD = 2'd3;
  logic [1:0]  r_state;
  logic [31:0] r_pc, r_buf, r_pc_out, r_next_pc_out, r_instr;
  logic        r_valid;
  logic        w_deliver, w_owed;
  logic [31:0] w_data, w_pc_inc;
  always_comb begin
    w_pc_inc  = r_pc + 32'd4;
    w_deliver = !bus.stall && ((r_state == WAIT && bus.fetch_rvalid) || r_state == HOLD);
    w_data    = (r_state == HOLD) ? r_buf : bus.fetch_rdata;
    // a response is still owed after a redirect cycle if one is accepted or pending and not arriving now
    w_owed    = (r_state == REQ && bus.fetch_ready) ||
                ((r_state == WAIT || r_state == DISCARD) && !bus.fetch_rvalid);
  end
  assign bus.fetch_req       = (r_state == REQ) && !reset;
  assign bus.fetch_addr      = r_pc;
  assign bus.pc_out          = r_pc_out;
  assign bus.next_pc_out     = r_next_pc_out;
  assign bus.instruction_out = r_instr;
  assign bus.valid_out       = r_valid;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= REQ;
      r_pc          <= RESET_VECTOR;
      r_buf         <= '0;
      r_pc_out      <= '0;
      r_next_pc_out <= '0;
      r_instr       <= '0;
      r_valid       <= 1'b0;
    end else if (bus.redirect) begin
      r_pc    <= {bus.redirect_target[31:2], 2'b00};
      r_valid <= 1'b0;
      r_buf   <= '0;
      r_state <= w_owed ? DISCARD : REQ;
    end else begin
      if (w_deliver) begin
        r_pc_out      <= r_pc;
        r_next_pc_out <= w_pc_inc;
        r_instr       <= w_data;
        r_valid       <= 1'b1;
        r_pc          <= w_pc_inc;
        r_state       <= REQ;
      end else begin
        if (!bus.stall) r_valid <= 1'b0;
        if (r_state == REQ && bus.fetch_ready) r_state <= WAIT;
        if (r_state == WAIT && bus.fetch_rvalid) begin
          r_buf   <= bus.fetch_rdata;
          r_state <= HOLD;
        end
        if (r_state == DISCARD && bus.fetch_rvalid) r_state <= REQ;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario tasks for fetch_unit with hand-computed expectations.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  fetch_unit_if bus();
  fetch_unit #(.RESET_VECTOR(32'h100)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.fetch_ready = 1'b0; bus.fetch_rvalid = 1'b0; bus.fetch_rdata = '0;
    bus.redirect = 1'b0; bus.redirect_target = '0; bus.stall = 1'b0;
    tick; tick;
    n_checks++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.fetch_req); end
    n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.valid_out); end
    n_checks++; if (bus.pc_out !== 32'h0 || bus.next_pc_out !== 32'h0 || bus.instruction_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_outs: got %h %h %h want 0 0 0", bus.pc_out, bus.next_pc_out, bus.instruction_out); end
    reset = 1'b0;
    #1;
    n_checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h100) begin
      n_fail++; $display("FAIL reset_first_req: got %b %h want 1 00000100", bus.fetch_req, bus.fetch_addr); end
  endtask

  task automatic test_sequential;
    logic [31:0] a, d;
    for (int i = 0; i < 3; i++) begin
      a = 32'h100 + 32'(4 * i);
      d = 32'h0000_1013 + 32'(i << 20);
      n_checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== a) begin
        n_fail++; $display("FAIL seq_addr%0d: got %b %h want 1 %h", i, bus.fetch_req, bus.fetch_addr, a); end
      bus.fetch_ready = 1'b1;
      tick;
      n_checks++; if (bus.valid_out !== 1'b0 || bus.fetch_req !== 1'b0) begin
        n_fail++; $display("FAIL seq_wait%0d: got valid %b req %b want 0 0", i, bus.valid_out, bus.fetch_req); end
      bus.fetch_rvalid = 1'b1; bus.fetch_rdata = d;
      tick;
      bus.fetch_rvalid = 1'b0;
      n_checks++; if (bus.valid_out !== 1'b1 || bus.pc_out !== a || bus.next_pc_out !== a + 32'd4 || bus.instruction_out !== d) begin
        n_fail++; $display("FAIL seq_out%0d: got %b %h %h %h want 1 %h %h %h", i, bus.valid_out, bus.pc_out,
                           bus.next_pc_out, bus.instruction_out, a, a + 32'd4, d); end
    end
    bus.fetch_ready = 1'b0;
  endtask

  task automatic test_not_ready;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h10C || bus.valid_out !== 1'b0) begin
        n_fail++; $display("FAIL not_ready%0d: got %b %h %b want 1 0000010c 0", i, bus.fetch_req, bus.fetch_addr, bus.valid_out); end
    end
  endtask

  task automatic test_stall;
    bus.redirect = 1'b1; bus.redirect_target = 32'h200;
    tick;
    bus.redirect = 1'b0;
    n_checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h200 || bus.valid_out !== 1'b0) begin
      n_fail++; $display("FAIL redirect_idle: got %b %h %b want 1 00000200 0", bus.fetch_req, bus.fetch_addr, bus.valid_out); end
    bus.fetch_ready = 1'b1;
    tick;
    bus.fetch_ready = 1'b0;
    bus.stall = 1'b1; bus.fetch_rvalid = 1'b1; bus.fetch_rdata = 32'h0050_0093;
    tick;
    bus.fetch_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.valid_out !== 1'b0 || bus.instruction_out !== 32'h0020_1013 || bus.pc_out !== 32'h108 || bus.fetch_req !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold%0d: got %b %h %h %b want 0 00201013 00000108 0", i, bus.valid_out,
                           bus.instruction_out, bus.pc_out, bus.fetch_req); end
      if (i < 2) tick;
    end
    bus.stall = 1'b0;
    tick;
    n_checks++; if (bus.valid_out !== 1'b1 || bus.instruction_out !== 32'h0050_0093 || bus.pc_out !== 32'h200 || bus.next_pc_out !== 32'h204) begin
      n_fail++; $display("FAIL stall_release: got %b %h %h %h want 1 00500093 00000200 00000204", bus.valid_out,
                         bus.instruction_out, bus.pc_out, bus.next_pc_out); end
    n_checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h204) begin
      n_fail++; $display("FAIL stall_next_req: got %b %h want 1 00000204", bus.fetch_req, bus.fetch_addr); end
  endtask

  task automatic test_redirect_wait;
    bus.fetch_ready = 1'b1;
    tick;
    bus.fetch_ready = 1'b0;
    bus.redirect = 1'b1; bus.redirect_target = 32'h403;
    tick;
    bus.redirect = 1'b0;
    n_checks++; if (bus.fetch_req !== 1'b0 || bus.valid_out !== 1'b0) begin
      n_fail++; $display("FAIL redir_wait_discard: got req %b valid %b want 0 0", bus.fetch_req, bus.valid_out); end
    bus.fetch_rvalid = 1'b1; bus.fetch_rdata = 32'hDEAD_BEEF;
    tick;
    bus.fetch_rvalid = 1'b0;
    n_checks++; if (bus.valid_out !== 1'b0 || bus.instruction_out !== 32'h0050_0093) begin
      n_fail++; $display("FAIL redir_wait_drop: got %b %h want 0 00500093", bus.valid_out, bus.instruction_out); end
    n_checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h400) begin
      n_fail++; $display("FAIL redir_wait_addr: got %b %h want 1 00000400", bus.fetch_req, bus.fetch_addr); end
  endtask

  task automatic test_redirect_stall_rvalid;
    bus.fetch_ready = 1'b1;
    tick;
    bus.fetch_ready = 1'b0;
    bus.redirect = 1'b1; bus.redirect_target = 32'h800; bus.stall = 1'b1;
    bus.fetch_rvalid = 1'b1; bus.fetch_rdata = 32'h1234_5678;
    tick;
    bus.redirect = 1'b0; bus.stall = 1'b0; bus.fetch_rvalid = 1'b0;
    n_checks++; if (bus.valid_out !== 1'b0 || bus.instruction_out !== 32'h0050_0093) begin
      n_fail++; $display("FAIL redir_stall_drop: got %b %h want 0 00500093", bus.valid_out, bus.instruction_out); end
    n_checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h800) begin
      n_fail++; $display("FAIL redir_stall_addr: got %b %h want 1 00000800", bus.fetch_req, bus.fetch_addr); end
  endtask

  task automatic test_wrap;
    bus.redirect = 1'b1; bus.redirect_target = 32'hFFFF_FFFC;
    tick;
    bus.redirect = 1'b0; bus.fetch_ready = 1'b1;
    tick;
    bus.fetch_ready = 1'b0; bus.fetch_rvalid = 1'b1; bus.fetch_rdata = 32'h0000_0013;
    tick;
    bus.fetch_rvalid = 1'b0;
    n_checks++; if (bus.valid_out !== 1'b1 || bus.pc_out !== 32'hFFFF_FFFC || bus.next_pc_out !== 32'h0 || bus.instruction_out !== 32'h13) begin
      n_fail++; $display("FAIL wrap_out: got %b %h %h %h want 1 fffffffc 00000000 00000013", bus.valid_out,
                         bus.pc_out, bus.next_pc_out, bus.instruction_out); end
    n_checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_addr: got %b %h want 1 00000000", bus.fetch_req, bus.fetch_addr); end
  endtask

  task automatic test_back_to_back;
    bus.fetch_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 32'h50;
    tick;
    bus.fetch_ready = 1'b0; bus.redirect = 1'b0;
    n_checks++; if (bus.fetch_req !== 1'b0 || bus.valid_out !== 1'b0) begin
      n_fail++; $display("FAIL redir_accept_discard: got req %b valid %b want 0 0", bus.fetch_req, bus.valid_out); end
    tick;
    n_checks++; if (bus.fetch_req !== 1'b0) begin
      n_fail++; $display("FAIL redir_accept_owed: got req %b want 0", bus.fetch_req); end
    bus.fetch_rvalid = 1'b1; bus.fetch_rdata = 32'hBAD0_0BAD;
    tick;
    bus.fetch_rvalid = 1'b0;
    n_checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h50 || bus.valid_out !== 1'b0) begin
      n_fail++; $display("FAIL redir_accept_addr: got %b %h %b want 1 00000050 0", bus.fetch_req, bus.fetch_addr, bus.valid_out); end
    bus.fetch_ready = 1'b1;
    tick;
    bus.fetch_ready = 1'b0; reset = 1'b1;
    tick;
    n_checks++; if (bus.fetch_req !== 1'b0 || bus.valid_out !== 1'b0 || bus.pc_out !== 32'h0 || bus.instruction_out !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset: got %b %b %h %h want 0 0 0 0", bus.fetch_req, bus.valid_out, bus.pc_out, bus.instruction_out); end
    reset = 1'b0;
    #1;
    n_checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h100) begin
      n_fail++; $display("FAIL mid_reset_addr: got %b %h want 1 00000100", bus.fetch_req, bus.fetch_addr); end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_not_ready;
    test_stall;
    test_redirect_wait;
    test_redirect_stall_rvalid;
    test_wrap;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
